// File: rtl/game_autoplayer.sv
// Scripted compass-move player for the adventure game FSM: replays a stored path
// one move at a time and reports whether the game was won, lost or the path ran out.
module game_autoplayer #(
  parameter int MAX_MOVES   = 8,
  parameter int STEP_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_we,
  input  logic [$clog2(MAX_MOVES)-1:0] load_addr,
  input  logic [1:0]                   load_dir,
  input  logic [$clog2(MAX_MOVES):0]   path_len,
  input  logic                         start,
  input  logic                         win,
  input  logic                         die,
  output logic                         game_reset,
  output logic                         n,
  output logic                         e,
  output logic                         s,
  output logic                         w,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   outcome,
  output logic [$clog2(MAX_MOVES):0]   moves_taken
);
  localparam int AW = $clog2(MAX_MOVES);
  localparam int LW = AW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRST  = 3'd1;
  localparam logic [2:0] MOVE  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [1:0] OUT_EXHAUSTED = 2'b00;
  localparam logic [1:0] OUT_WIN       = 2'b01;
  localparam logic [1:0] OUT_DIE       = 2'b10;

  localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_MOVES);
  localparam logic [3:0]    STEP_LAST = 4'(STEP_CYCLES - 1);

  logic [2:0]    state;
  logic [1:0]    path [MAX_MOVES];
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_next;
  logic [LW-1:0] idx_plus1;
  logic [LW-1:0] len;
  logic [3:0]    cnt;
  logic [3:0]    dirs;

  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] v);
    return (v > MAX_LEN) ? MAX_LEN : v;
  endfunction

  // Returns {n,e,s,w}; code 00=N, 01=E, 10=S, 11=W.
  function automatic logic [3:0] dir_onehot(input logic [1:0] code);
    return 4'b1000 >> code;
  endfunction

  assign {n, e, s, w} = dirs;
  assign idx_next     = idx + AW'(1);
  assign idx_plus1    = LW'(idx) + LW'(1);

  // Path memory only accepts writes while no run is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_MOVES; i++) path[i] <= 2'b00;
    end else if (load_we && (state == IDLE || state == DONE)) begin
      path[load_addr] <= load_dir;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      game_reset  <= 1'b0;
      dirs        <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      outcome     <= OUT_EXHAUSTED;
      moves_taken <= '0;
      idx         <= '0;
      len         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == IDLE || start) begin
            done        <= 1'b0;
            outcome     <= OUT_EXHAUSTED;
            moves_taken <= '0;
            idx         <= '0;
          end
          if (start) begin
            state      <= GRST;
            game_reset <= 1'b1;
            busy       <= 1'b1;
          end
        end
        GRST: begin
          game_reset <= 1'b0;
          len        <= sat_len(path_len);
          if (path_len == '0) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            outcome <= OUT_EXHAUSTED;
          end else begin
            state       <= MOVE;
            dirs        <= dir_onehot(path[0]);
            moves_taken <= LW'(1);
            cnt         <= STEP_LAST;
          end
        end
        MOVE: begin
          if (cnt == 4'd0) begin
            state <= CHECK;
            dirs  <= 4'b0000;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CHECK: begin
          if (win || die || idx_plus1 == len) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            outcome <= win ? OUT_WIN : (die ? OUT_DIE : OUT_EXHAUSTED);
          end else begin
            state       <= MOVE;
            idx         <= idx_next;
            dirs        <= dir_onehot(path[idx_next]);
            moves_taken <= moves_taken + LW'(1);
            cnt         <= STEP_LAST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_autoplayer.sv
// Directed bench for game_autoplayer: two instances (1- and 3-cycle steps) with a
// win/die stub standing in for the game, traced cycle by cycle after each start.
module tb_game_autoplayer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_we = 1'b0;
  logic [2:0] load_addr = '0;
  logic [1:0] load_dir = '0;
  logic [3:0] path_len = '0;
  logic       start = 1'b0;
  logic [3:0] win_at = '0;
  logic [3:0] die_at = '0;

  logic       win1, die1, g1o, n1, e1, s1, w1, b1o, dn1o;
  logic [1:0] o1o;
  logic [3:0] m1o;
  logic       win3, die3, g3o, n3, e3, s3, w3, b3o, dn3o;
  logic [1:0] o3o;
  logic [3:0] m3o;

  logic [3:0] d1 [64];
  logic [3:0] d3 [64];
  logic       g1 [64];
  logic       g3 [64];
  logic       b1 [64];
  logic       b3 [64];
  logic       dn1 [64];
  logic       dn3 [64];
  logic [1:0] o1 [64];
  logic [1:0] o3 [64];
  logic [3:0] m1 [64];
  logic [3:0] m3 [64];

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  // The game stub wins/dies once the given number of moves has been issued.
  assign win1 = (win_at != 0) && (m1o >= win_at);
  assign die1 = (die_at != 0) && (m1o >= die_at);
  assign win3 = (win_at != 0) && (m3o >= win_at);
  assign die3 = (die_at != 0) && (m3o >= die_at);

  game_autoplayer #(.MAX_MOVES(8), .STEP_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_dir(load_dir), .path_len(path_len), .start(start), .win(win1), .die(die1),
    .game_reset(g1o), .n(n1), .e(e1), .s(s1), .w(w1), .busy(b1o), .done(dn1o),
    .outcome(o1o), .moves_taken(m1o));

  game_autoplayer #(.MAX_MOVES(8), .STEP_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_dir(load_dir), .path_len(path_len), .start(start), .win(win3), .die(die3),
    .game_reset(g3o), .n(n3), .e(e3), .s(s3), .w(w3), .busy(b3o), .done(dn3o),
    .outcome(o3o), .moves_taken(m3o));

  function automatic logic [3:0] exp_dir(input logic [1:0] code);
    case (code)
      2'b00:   return 4'b1000;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic load_path(input logic [15:0] codes, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      load_we = 1'b1; load_addr = 3'(i); load_dir = codes[2*i +: 2];
      @(posedge clk); #1;
    end
    load_we = 1'b0;
  endtask

  // Trace entry c is the state during cycle c, where start is sampled at edge 0.
  task automatic run(input int ncyc, input bit hold, input int wc,
                     input logic [2:0] wa, input logic [1:0] wd);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (!hold && c == 1) start = 1'b0;
      if (c == wc) begin load_we = 1'b1; load_addr = wa; load_dir = wd; end
      if (c == wc + 1) load_we = 1'b0;
      d1[c] = {n1, e1, s1, w1}; g1[c] = g1o; b1[c] = b1o; dn1[c] = dn1o;
      o1[c] = o1o; m1[c] = m1o;
      d3[c] = {n3, e3, s3, w3}; g3[c] = g3o; b3[c] = b3o; dn3[c] = dn3o;
      o3[c] = o3o; m3[c] = m3o;
    end
    start = 1'b0;
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    total++; if ({g1o, n1, e1, s1, w1, b1o, dn1o} !== 7'b0) $display("FAIL reset_ctrl got %b want 0", {g1o, n1, e1, s1, w1, b1o, dn1o}); else passed++;
    total++; if (o1o !== 2'b00) $display("FAIL reset_outcome got %b want 00", o1o); else passed++;
    total++; if (m1o !== 4'd0) $display("FAIL reset_moves got %0d want 0", m1o); else passed++;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_die_path();
    logic [3:0] exp [10];
    exp = '{4'b0, 4'b0, 4'b0100, 4'b0, 4'b0010, 4'b0, 4'b0100, 4'b0, 4'b0, 4'b0};
    load_path(16'h0019, 3);  // E,S,E
    path_len = 4'd3; win_at = 4'd0; die_at = 4'd3;
    run(40, 1'b0, 0, 3'd0, 2'b00);
    total++; if (g1[1] !== 1'b1 || g1[2] !== 1'b0) $display("FAIL die_grst got %b%b want 10", g1[1], g1[2]); else passed++;
    total++; if (m1[1] !== 4'd0) $display("FAIL die_moves_cleared got %0d want 0", m1[1]); else passed++;
    for (int c = 1; c <= 9; c++) begin
      total++; if (d1[c] !== exp[c]) $display("FAIL die_dir c%0d got %b want %b", c, d1[c], exp[c]); else passed++;
    end
    total++; if (dn1[7] !== 1'b0 || b1[7] !== 1'b1) $display("FAIL die_check7 done=%b busy=%b want 0 1", dn1[7], b1[7]); else passed++;
    total++; if (dn1[8] !== 1'b1 || b1[8] !== 1'b0) $display("FAIL die_done8 done=%b busy=%b want 1 0", dn1[8], b1[8]); else passed++;
    total++; if (o1[8] !== 2'b10) $display("FAIL die_outcome got %b want 10", o1[8]); else passed++;
    total++; if (m1[8] !== 4'd3) $display("FAIL die_moves got %0d want 3", m1[8]); else passed++;
  endtask

  task automatic test_win_priority();
    load_path(16'h00E4, 4);  // N,E,S,W
    path_len = 4'd4; win_at = 4'd2; die_at = 4'd2;
    run(40, 1'b0, 0, 3'd0, 2'b00);
    total++; if (d1[2] !== 4'b1000 || d1[4] !== 4'b0100) $display("FAIL win_moves got %b %b want 1000 0100", d1[2], d1[4]); else passed++;
    for (int c = 5; c <= 12; c++) begin
      total++; if (d1[c] !== 4'b0) $display("FAIL win_no_third c%0d got %b want 0000", c, d1[c]); else passed++;
    end
    total++; if (dn1[5] !== 1'b0 || dn1[6] !== 1'b1) $display("FAIL win_done got %b%b want 01", dn1[5], dn1[6]); else passed++;
    total++; if (o1[6] !== 2'b01) $display("FAIL win_outcome got %b want 01", o1[6]); else passed++;
    total++; if (m1[6] !== 4'd2) $display("FAIL win_moves_taken got %0d want 2", m1[6]); else passed++;
  endtask

  task automatic test_exhaustion();
    logic [3:0] want;
    path_len = 4'd4; win_at = 4'd0; die_at = 4'd0;
    run(40, 1'b0, 0, 3'd0, 2'b00);
    total++; if (g3[1] !== 1'b1) $display("FAIL exh_grst got %b want 1", g3[1]); else passed++;
    for (int c = 2; c <= 20; c++) begin
      want = 4'b0;
      if (c <= 17 && ((c - 2) % 4) < 3) want = exp_dir(2'((c - 2) / 4));
      total++; if (d3[c] !== want) $display("FAIL exh_dir c%0d got %b want %b", c, d3[c], want); else passed++;
    end
    total++; if (dn3[17] !== 1'b0 || dn3[18] !== 1'b1) $display("FAIL exh_done got %b%b want 01", dn3[17], dn3[18]); else passed++;
    total++; if (b3[17] !== 1'b1 || b3[18] !== 1'b0) $display("FAIL exh_busy got %b%b want 10", b3[17], b3[18]); else passed++;
    total++; if (o3[18] !== 2'b00 || m3[18] !== 4'd4) $display("FAIL exh_result got %b/%0d want 00/4", o3[18], m3[18]); else passed++;
  endtask

  task automatic test_zero_len();
    path_len = 4'd0; win_at = 4'd0; die_at = 4'd0;
    run(12, 1'b0, 0, 3'd0, 2'b00);
    total++; if (g1[1] !== 1'b1 || g1[2] !== 1'b0) $display("FAIL zero_grst got %b%b want 10", g1[1], g1[2]); else passed++;
    total++; if (dn1[1] !== 1'b0 || dn1[2] !== 1'b1) $display("FAIL zero_done got %b%b want 01", dn1[1], dn1[2]); else passed++;
    total++; if (o1[2] !== 2'b00 || m1[2] !== 4'd0) $display("FAIL zero_result got %b/%0d want 00/0", o1[2], m1[2]); else passed++;
    for (int c = 1; c <= 12; c++) begin
      total++; if (d1[c] !== 4'b0) $display("FAIL zero_dir c%0d got %b want 0000", c, d1[c]); else passed++;
    end
  endtask

  task automatic test_onehot();
    logic [15:0] rc;
    logic [3:0] want;
    rc = 16'($urandom);
    load_path(rc, 8);
    path_len = 4'd15; win_at = 4'd0; die_at = 4'd0;  // saturates to 8
    run(40, 1'b0, 0, 3'd0, 2'b00);
    for (int c = 1; c <= 24; c++) begin
      want = 4'b0;
      if (c >= 2 && c <= 17 && (c % 2) == 0) want = exp_dir(rc[(c - 2) +: 2]);
      total++; if ($countones(d1[c]) > 1) $display("FAIL onehot_multi c%0d got %b want at most one", c, d1[c]); else passed++;
      total++; if (d1[c] !== want) $display("FAIL onehot_seq c%0d got %b want %b", c, d1[c], want); else passed++;
    end
    total++; if (dn1[17] !== 1'b0 || dn1[18] !== 1'b1) $display("FAIL onehot_done got %b%b want 01", dn1[17], dn1[18]); else passed++;
    total++; if (o1[18] !== 2'b00 || m1[18] !== 4'd8) $display("FAIL onehot_result got %b/%0d want 00/8", o1[18], m1[18]); else passed++;
  endtask

  task automatic test_abort_lockout();
    load_path(16'h00E4, 4);
    path_len = 4'd4; win_at = 4'd0; die_at = 4'd0;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
    end
    total++; if (e1 !== 1'b1) $display("FAIL abort_second_move got %b want e=1", {n1, e1, s1, w1}); else passed++;
    reset = 1'b0;
    #1;
    total++; if ({g1o, n1, e1, s1, w1, b1o, dn1o} !== 7'b0) $display("FAIL abort_drop got %b want 0", {g1o, n1, e1, s1, w1, b1o, dn1o}); else passed++;
    total++; if (o1o !== 2'b00 || m1o !== 4'd0) $display("FAIL abort_status got %b/%0d want 00/0", o1o, m1o); else passed++;
    @(posedge clk); #1 reset = 1'b1;
    load_path(16'h0003, 1);  // addr0 = W, rest cleared to N
    path_len = 4'd2;
    run(40, 1'b0, 3, 3'd0, 2'b01);  // write E to addr0 while busy
    total++; if (d1[2] !== 4'b0001 || d1[4] !== 4'b1000) $display("FAIL abort_cleared_mem got %b %b want 0001 1000", d1[2], d1[4]); else passed++;
    total++; if (dn1[6] !== 1'b1 || m1[6] !== 4'd2) $display("FAIL abort_rerun got %b/%0d want 1/2", dn1[6], m1[6]); else passed++;
    path_len = 4'd1;
    run(8, 1'b1, 0, 3'd0, 2'b00);
    total++; if (d1[2] !== 4'b0001) $display("FAIL lockout_write got %b want 0001", d1[2]); else passed++;
    total++; if (dn1[4] !== 1'b1 || g1[4] !== 1'b0) $display("FAIL hold_done got done=%b grst=%b want 1 0", dn1[4], g1[4]); else passed++;
    total++; if (g1[5] !== 1'b1 || dn1[5] !== 1'b0) $display("FAIL hold_restart got grst=%b done=%b want 1 0", g1[5], dn1[5]); else passed++;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_die_path();
    test_win_priority();
    test_exhaustion();
    test_zero_len();
    test_onehot();
    test_abort_lockout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
